// File: rtl/menu_bmp_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | menu_bmp_loader: streams a 24/32-bpp BMP download into SDRAM words.       |
// | Optional BMP_CENTER_EN centres small images.   Rev 1.0                    |
// +--------------------------------------------------------------------------+
module menu_bmp_loader #(
  parameter int         MAX_W     = 512,
  parameter int         LINE_LOG2 = 9,
  parameter int         MAX_H     = 312,
  parameter int         ADDR_W    = 22,
  parameter logic [7:0] IDX       = 8'd0
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_d,
  output logic              loaded,
  output logic              error,
  output logic [9:0]        img_w,
  output logic [8:0]        img_h
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HEADER   = 3'd1,
    S_SKIP     = 3'd2,
    S_PIXEL    = 3'd3,
    S_PAD      = 3'd4,
    S_DONE     = 3'd5,
    S_WAIT_ACK = 3'd6,
    S_ERROR    = 3'd7
  } state_t;

  state_t      r_state;
  logic        r_wr_d;
  logic        r_dl_d;
  logic        r_magic_b;
  logic        r_magic_m;
  logic [31:0] r_data_start;
  logic [31:0] r_width;
  logic [31:0] r_height;
  logic [7:0]  r_bpp_lo;
  logic        r_bpp32;
  logic        r_topdown;
  logic [9:0]  r_x;
  logic [8:0]  r_row;
  logic [1:0]  r_bcnt;
  logic [1:0]  r_pad;
  logic [7:0]  r_blue;
  logic [7:0]  r_green;
  logic [7:0]  r_red;
  logic [9:0]  r_x_off;
  logic [8:0]  r_y_off;

  logic              w_dl;
  logic              w_dl_rise;
  logic              w_dl_fall;
  logic              w_ev;
  logic [15:0]       w_bpp;
  logic [31:0]       w_h_abs;
  logic              w_w_ok;
  logic              w_h_ok;
  logic              w_hdr_ok;
  logic              w_last_byte;
  logic [7:0]        w_red;
  logic [8:0]        w_line;
  logic [ADDR_W-1:0] w_addr;
  logic [9:0]        w_x_off;
  logic [8:0]        w_y_off;

  assign w_dl      = ioctl_download && (ioctl_index == IDX);
  assign w_dl_rise = w_dl && !r_dl_d;
  assign w_dl_fall = !w_dl && r_dl_d;
  assign w_ev      = ioctl_wr && !r_wr_d && w_dl;

  // Header checks use the bpp high byte arriving on this very strobe.
  assign w_bpp    = {ioctl_dout, r_bpp_lo};
  assign w_h_abs  = r_height[31] ? (~r_height + 32'd1) : r_height;
  assign w_w_ok   = !r_width[31] && (r_width != 32'd0) && (r_width <= 32'(MAX_W));
  assign w_h_ok   = (w_h_abs != 32'd0) && (w_h_abs <= 32'(MAX_H));
  assign w_hdr_ok = r_magic_b && r_magic_m && ((w_bpp == 16'd24) || (w_bpp == 16'd32))
                    && w_w_ok && w_h_ok && (r_data_start >= 32'd30);

`ifdef BMP_CENTER_EN
  assign w_x_off = 10'((11'(MAX_W) - {1'b0, r_width[9:0]}) >> 1);
  assign w_y_off = 9'((10'(MAX_H) - {1'b0, w_h_abs[8:0]}) >> 1);
`else
  assign w_x_off = '0;
  assign w_y_off = '0;
`endif

  assign w_last_byte = r_bpp32 ? (r_bcnt == 2'd3) : (r_bcnt == 2'd2);
  assign w_red       = r_bpp32 ? r_red : ioctl_dout;
  assign w_line      = r_topdown ? r_row : (img_h - 9'd1 - r_row);
  assign w_addr      = ((ADDR_W'(w_line) + ADDR_W'(r_y_off)) << LINE_LOG2)
                       + ADDR_W'(r_x) + ADDR_W'(r_x_off);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wr_d       <= 1'b0;
      // Treat the download as already running so a reset mid-file never restarts it.
      r_dl_d       <= 1'b1;
      r_magic_b    <= 1'b0;
      r_magic_m    <= 1'b0;
      r_data_start <= '0;
      r_width      <= '0;
      r_height     <= '0;
      r_bpp_lo     <= '0;
      r_bpp32      <= 1'b0;
      r_topdown    <= 1'b0;
      r_x          <= '0;
      r_row        <= '0;
      r_bcnt       <= '0;
      r_pad        <= '0;
      r_blue       <= '0;
      r_green      <= '0;
      r_red        <= '0;
      r_x_off      <= '0;
      r_y_off      <= '0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      mem_d        <= '0;
      loaded       <= 1'b0;
      error        <= 1'b0;
      img_w        <= '0;
      img_h        <= '0;
    end else begin
      r_wr_d <= ioctl_wr;
      r_dl_d <= w_dl;
      if (w_dl_rise) begin
        r_state   <= S_HEADER;
        loaded    <= 1'b0;
        error     <= 1'b0;
        img_w     <= '0;
        img_h     <= '0;
        r_magic_b <= 1'b0;
        r_magic_m <= 1'b0;
      end else if (w_dl_fall) begin
        case (r_state)
          S_DONE:                           r_state <= S_WAIT_ACK;
          S_HEADER, S_SKIP, S_PIXEL, S_PAD: begin
            error   <= 1'b1;
            r_state <= S_ERROR;
          end
          default: ;
        endcase
      end else if (r_state == S_WAIT_ACK) begin
        if (mem_req == mem_ack) begin
          loaded  <= 1'b1;
          r_state <= S_IDLE;
        end
      end else if (w_ev) begin
        case (r_state)
          S_HEADER: begin
            case (ioctl_addr)
              25'd0:  r_magic_b           <= (ioctl_dout == 8'h42);
              25'd1:  r_magic_m           <= (ioctl_dout == 8'h4D);
              25'd10: r_data_start[7:0]   <= ioctl_dout;
              25'd11: r_data_start[15:8]  <= ioctl_dout;
              25'd12: r_data_start[23:16] <= ioctl_dout;
              25'd13: r_data_start[31:24] <= ioctl_dout;
              25'd18: r_width[7:0]        <= ioctl_dout;
              25'd19: r_width[15:8]       <= ioctl_dout;
              25'd20: r_width[23:16]      <= ioctl_dout;
              25'd21: r_width[31:24]      <= ioctl_dout;
              25'd22: r_height[7:0]       <= ioctl_dout;
              25'd23: r_height[15:8]      <= ioctl_dout;
              25'd24: r_height[23:16]     <= ioctl_dout;
              25'd25: r_height[31:24]     <= ioctl_dout;
              25'd28: r_bpp_lo            <= ioctl_dout;
              25'd29: begin
                if (w_hdr_ok) begin
                  img_w     <= r_width[9:0];
                  img_h     <= w_h_abs[8:0];
                  r_topdown <= r_height[31];
                  r_bpp32   <= (w_bpp == 16'd32);
                  r_x_off   <= w_x_off;
                  r_y_off   <= w_y_off;
                  r_x       <= '0;
                  r_row     <= '0;
                  r_bcnt    <= '0;
                  r_state   <= S_SKIP;
                end else begin
                  error   <= 1'b1;
                  r_state <= S_ERROR;
                end
              end
              default: ;
            endcase
          end
          S_SKIP: begin
            if ({7'd0, ioctl_addr} == r_data_start) begin
              r_blue  <= ioctl_dout;
              r_bcnt  <= 2'd1;
              r_state <= S_PIXEL;
            end
          end
          S_PIXEL: begin
            case (r_bcnt)
              2'd0:    r_blue  <= ioctl_dout;
              2'd1:    r_green <= ioctl_dout;
              2'd2:    r_red   <= ioctl_dout;
              default: ;
            endcase
            if (!w_last_byte) begin
              r_bcnt <= r_bcnt + 2'd1;
            end else if (mem_req != mem_ack) begin
              error   <= 1'b1;
              r_state <= S_ERROR;
            end else begin
              mem_req  <= ~mem_req;
              mem_addr <= w_addr;
              mem_d    <= {8'h00, w_red, r_green, r_blue};
              r_bcnt   <= '0;
              if (r_x == img_w - 10'd1) begin
                if (r_row == img_h - 9'd1) begin
                  r_state <= S_DONE;
                end else if (!r_bpp32 && (img_w[1:0] != 2'd0)) begin
                  // 24-bpp rows pad to 4 bytes; pad length equals w mod 4.
                  r_pad   <= img_w[1:0];
                  r_state <= S_PAD;
                end else begin
                  r_x   <= '0;
                  r_row <= r_row + 9'd1;
                end
              end else begin
                r_x <= r_x + 10'd1;
              end
            end
          end
          S_PAD: begin
            if (r_pad == 2'd1) begin
              r_x     <= '0;
              r_row   <= r_row + 9'd1;
              r_state <= S_PIXEL;
            end else begin
              r_pad <= r_pad - 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_menu_bmp_loader.sv
`default_nettype none
// Randomised and directed BMP downloads compared against a file-layout reference model.
module tb_menu_bmp_loader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        mem_req;
  logic        mem_ack;
  logic [21:0] mem_addr;
  logic [31:0] mem_d;
  logic        loaded;
  logic        error;
  logic [9:0]  img_w;
  logic [8:0]  img_h;

  menu_bmp_loader dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_d(mem_d), .loaded(loaded), .error(error),
    .img_w(img_w), .img_h(img_h)
  );

  always #5 clk_sys = ~clk_sys;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  file_mem [0:2047];
  int          cur_w, cur_h, cur_bpp, cur_ds, full_len;
  logic [31:0] obs_addr[$], obs_data[$], exp_addr[$], exp_data[$];
  bit          exp_loaded, exp_error;
  int          exp_w, exp_h;
  bit          hold_ack = 1'b0;
  logic        prev_req = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // SDRAM responder: acknowledges one cycle after each request unless held.
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (!hold_ack && (mem_ack != mem_req)) mem_ack = mem_req;
    end
  end

  initial begin
    forever begin
      @(negedge clk_sys);
      if (reset) prev_req = mem_req;
      else if (mem_req != prev_req) begin
        obs_addr.push_back({10'd0, mem_addr});
        obs_data.push_back(mem_d);
        prev_req = mem_req;
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] oa(input int i);
    return (i >= 0 && i < obs_addr.size()) ? obs_addr[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] od(input int i);
    return (i >= 0 && i < obs_data.size()) ? obs_data[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic put32(input int a, input logic [31:0] v);
    for (int k = 0; k < 4; k++) file_mem[a+k] = v[8*k +: 8];
  endtask

  task automatic build(input int w, input int h, input int bpp, input int ds);
    int habs, stride;
    cur_w = w; cur_h = h; cur_bpp = bpp; cur_ds = ds;
    habs   = (h < 0) ? -h : h;
    stride = ((w * (bpp / 8) + 3) / 4) * 4;
    full_len = ds + stride * habs;
    if (full_len > 2048) full_len = 2048;
    for (int i = 0; i < 2048; i++) file_mem[i] = 8'($urandom);
    file_mem[0] = 8'h42;
    file_mem[1] = 8'h4D;
    put32(10, ds);
    put32(18, w);
    put32(22, h);
    file_mem[28] = 8'(bpp);
    file_mem[29] = 8'(bpp >> 8);
  endtask

  // Expected writes derived from the BMP file layout; hold_p1 models a stalled SDRAM.
  task automatic model(input int len, input bit hold_p1);
    int habs, bpc, stride, row, x, off, line, xoff, yoff;
    bit ok, complete;
    exp_addr.delete();
    exp_data.delete();
    habs = (cur_h < 0) ? -cur_h : cur_h;
    ok = (cur_bpp == 24 || cur_bpp == 32) && cur_w >= 1 && cur_w <= 512
         && habs >= 1 && habs <= 312 && cur_ds >= 30 && len >= 30;
    exp_w = ok ? cur_w : 0;
    exp_h = ok ? habs : 0;
    exp_loaded = 1'b0;
    exp_error  = 1'b1;
    if (!ok) return;
`ifdef BMP_CENTER_EN
    xoff = (512 - cur_w) / 2;
    yoff = (312 - habs) / 2;
`else
    xoff = 0;
    yoff = 0;
`endif
    bpc    = cur_bpp / 8;
    stride = ((cur_w * bpc + 3) / 4) * 4;
    complete = 1'b1;
    for (int p = 0; p < cur_w * habs; p++) begin
      row = p / cur_w;
      x   = p % cur_w;
      off = cur_ds + row * stride + x * bpc;
      if (off + bpc - 1 >= len) begin
        complete = 1'b0;
        break;
      end
      if (hold_p1 && p == 1) return;
      line = (cur_h > 0) ? (habs - 1 - row) : row;
      exp_addr.push_back(32'(((line + yoff) * 512 + x + xoff) % (1 << 22)));
      exp_data.push_back({8'h00, file_mem[off+2], file_mem[off+1], file_mem[off]});
    end
    exp_loaded = complete;
    exp_error  = !complete;
  endtask

  task automatic send_range(input int from, input int to);
    for (int i = from; i < to; i++) begin
      @(negedge clk_sys);
      ioctl_addr = 25'(i);
      ioctl_dout = file_mem[i];
      ioctl_wr   = 1'b1;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      @(negedge clk_sys);
    end
  endtask

  task automatic run_dl(input int len, input logic [7:0] idx);
    obs_addr.delete();
    obs_data.delete();
    @(negedge clk_sys);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    repeat (3) @(negedge clk_sys);
    send_range(0, len);
    repeat (2) @(negedge clk_sys);
    ioctl_download = 1'b0;
    for (int k = 0; k < 20 && !(loaded || error); k++) @(negedge clk_sys);
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic check_result(input string tag);
    chk({tag, ".nwords"}, obs_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      chk($sformatf("%s.addr%0d", tag, i), obs_addr[i], exp_addr[i]);
      chk($sformatf("%s.data%0d", tag, i), obs_data[i], exp_data[i]);
    end
    chk({tag, ".loaded"}, 32'(loaded), 32'(exp_loaded));
    chk({tag, ".error"},  32'(error),  32'(exp_error));
    chk({tag, ".img_w"},  32'(img_w),  exp_w);
    chk({tag, ".img_h"},  32'(img_h),  exp_h);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".mem_req"},  32'(mem_req), 32'd0);
    chk({tag, ".mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, ".mem_d"},    mem_d, 32'd0);
    chk({tag, ".loaded"},   32'(loaded), 32'd0);
    chk({tag, ".error"},    32'(error), 32'd0);
    chk({tag, ".img_w"},    32'(img_w), 32'd0);
    chk({tag, ".img_h"},    32'(img_h), 32'd0);
  endtask

  task automatic run_case(input string tag, input int w, input int h, input int bpp,
                          input int ds, input int len);
    build(w, h, bpp, ds);
    model(len < 0 ? full_len : len, 1'b0);
    run_dl(len < 0 ? full_len : len, 8'd0);
    check_result(tag);
  endtask

  initial begin
    int w, h, bpp, ds, len;
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
    check_zero("reset");

    // 4x2 bottom-up, no row padding
    run_case("bu4x2", 4, 2, 24, 54, -1);
`ifndef BMP_CENTER_EN
    chk("bu4x2.first_addr", oa(0), 32'd512);
    chk("bu4x2.last_addr", oa(7), 32'd3);
`endif

    // 3x2 top-down with 3 pad bytes per row
    build(3, -2, 24, 54);
    file_mem[54] = 8'h10; file_mem[55] = 8'h20; file_mem[56] = 8'h30;
    model(full_len, 1'b0);
    run_dl(full_len, 8'd0);
    check_result("td3x2");
    chk("td3x2.first_data", od(0), 32'h0030_2010);
`ifndef BMP_CENTER_EN
    chk("td3x2.first_addr", oa(0), 32'd0);
    chk("td3x2.row1_addr", oa(3), 32'd512);
    chk("td3x2.row1_last", oa(5), 32'd514);
`endif

    // 2x1 32bpp with opaque alpha
    build(2, 1, 32, 54);
    file_mem[57] = 8'hFF; file_mem[61] = 8'hFF;
    model(full_len, 1'b0);
    run_dl(full_len, 8'd0);
    check_result("a32");
    chk("a32.top_byte", od(0) >> 24, 32'd0);

    run_case("bpp16", 4, 2, 16, 54, 40);
    run_case("w600", 600, 2, 24, 54, 40);
    run_case("w513", 513, 1, 24, 54, 40);
    run_case("h313", 1, 313, 24, 54, 40);
    run_case("h0", 4, 0, 24, 54, 40);
    run_case("w0", 0, 2, 24, 54, 40);
    run_case("ds29", 4, 2, 24, 29, 60);
    run_case("wmax", 512, 1, 24, 54, -1);
    run_case("hmax", 1, -312, 32, 54, -1);
    run_case("trunc", 4, 4, 24, 54, 54 + 30);

    // SDRAM ack withheld across two pixels
    build(4, 2, 24, 54);
    model(full_len, 1'b1);
    hold_ack = 1'b1;
    run_dl(full_len, 8'd0);
    check_result("overrun");
    hold_ack = 1'b0;
    repeat (3) @(negedge clk_sys);

    // top-down 4x2 (centred when the option is built in)
    run_case("ctr", 4, -2, 24, 54, -1);
`ifdef BMP_CENTER_EN
    chk("ctr.first_addr", oa(0), 32'd79614);
`endif

    for (int it = 0; it < 8; it++) begin
      w   = int'($urandom_range(1, 9));
      h   = int'($urandom_range(1, 4));
      if ($urandom_range(0, 1) == 1) h = -h;
      bpp = ($urandom_range(0, 1) == 1) ? 32 : 24;
      ds  = int'($urandom_range(30, 70));
      build(w, h, bpp, ds);
      if ($urandom_range(0, 2) == 0) len = ds + int'($urandom_range(0, full_len - ds - 1));
      else len = full_len + int'($urandom_range(0, 3));
      model(len, 1'b0);
      run_dl(len, 8'd0);
      check_result($sformatf("rnd%0d", it));
    end

    // reset in the middle of pixel data; the remainder of the file must be ignored
    build(4, 4, 24, 54);
    obs_addr.delete();
    obs_data.delete();
    @(negedge clk_sys);
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    repeat (3) @(negedge clk_sys);
    send_range(0, 54 + 20);
    @(negedge clk_sys);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    #2 reset = 1'b0;
    @(negedge clk_sys);
    check_zero("rst_mid");
    obs_addr.delete();
    obs_data.delete();
    send_range(54 + 20, full_len);
    repeat (2) @(negedge clk_sys);
    ioctl_download = 1'b0;
    repeat (10) @(negedge clk_sys);
    chk("rst_mid.after_words", obs_addr.size(), 32'd0);
    check_zero("rst_mid.after");

    // download to a different slot is not ours
    build(4, 2, 24, 54);
    run_dl(full_len, 8'd1);
    chk("idx.words", obs_addr.size(), 32'd0);
    chk("idx.loaded", 32'(loaded), 32'd0);
    chk("idx.img_w", 32'(img_w), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/menu_bmp_loader.md
Name: menu_bmp_loader

Overview:
Streaming BMP decoder for the MENU core's background picture. It snoops the data_io download stream and parses the BMP header. It converts 24/32-bpp bottom-up or top-down pixel rows into one 32-bit word per pixel and issues each word to an SDRAM write port with a req/ack toggle handshake, in framebuffer line order. It replaces the fixed-offset inline loader and generalises it in framebuffer geometry, pixel depth, row orientation, validation and completion status.

Parameters:
MAX_W, 512, maximum accepted image width in pixels; framebuffer line stride
LINE_LOG2, 9, log2 of line stride in words; MAX_W must be <= 2**LINE_LOG2
MAX_H, 312, maximum accepted image height (lines)
ADDR_W, 22, word address width on mem_addr
IDX, 8'd0, ioctl_index value this block accepts; other indices are ignored

Ports:
clk_sys  in  1  clock (clk_ram domain)
reset  in  1  asynchronous, active-high reset
ioctl_download  in  1  download in progress
ioctl_index  in  8  download slot
ioctl_wr  in  1  byte strobe; a rising edge marks one valid byte
ioctl_addr  in  25  byte offset in file
ioctl_dout  in  8  file byte
mem_req  out  1  toggles once per word to write
mem_ack  in  1  SDRAM port acknowledge; the word is complete when mem_ack == mem_req
mem_addr  out  ADDR_W  word address = (line << LINE_LOG2) + x
mem_d  out  32  {8'h00, R, G, B}
loaded  out  1  valid image fully written
error  out  1  sticky: header invalid, truncated file or overrun
img_w  out  10  accepted width
img_h  out  9  accepted height (absolute)

Behaviour:
- Reset: all outputs 0, state IDLE, byte-edge detector cleared.
- Byte event = ioctl_wr rising edge (registered previous value) while ioctl_download=1 and ioctl_index==IDX. Only byte events advance parsing.
- Download rising edge (any state): clear loaded, error, img_w, img_h; state HEADER. Reset mid-download forces IDLE, and the rest of that download is ignored.
- HEADER: capture by ioctl_addr:
  - 0,1 = 'B','M'
  - 10..13 = data_start (LE)
  - 18..21 = width (LE, signed)
  - 22..25 = height (LE, signed)
  - 28..29 = bpp
- At byte 29, validate: magic ok, bpp 24 or 32, 1<=width<=MAX_W, 1<=|height|<=MAX_H, data_start>=30. Fail -> ERROR with error=1. Pass -> SKIP.
- SKIP: discard bytes until ioctl_addr==data_start, then enter PIXEL on that same byte.
- PIXEL: bytes arrive in B,G,R(,A) order; the 4th byte is discarded at 32bpp. On the final byte of a pixel, load mem_addr/mem_d and toggle mem_req.
  - line = height>0 ? (h-1-row) : row.
  - x increments per pixel. At x==w, go to PAD, or to the next row directly if no padding is needed.
- PAD (24bpp only): skip (4 - (3*w mod 4)) mod 4 bytes, then row++, x=0.
- After the last pixel of row h-1: DONE, and trailing bytes are ignored.
- Overrun: a pixel completes while mem_req != mem_ack -> error=1, ERROR. The word is not issued.
- Download falling edge:
  - DONE: loaded=1 once mem_req==mem_ack.
  - PIXEL, PAD or SKIP: truncated, error=1.
  - HEADER: error=1.
  - ERROR: stays ERROR, loaded=0.
- loaded and error are never both 1. Both hold until the next download start or reset.
- Latency: mem_req toggles 1 clk_sys after the byte event of the pixel's last byte.
- All address arithmetic is unsigned, truncated to ADDR_W.

Optional Feature:
BMP_CENTER_EN
- Defined: images smaller than the framebuffer are centred. x_off=(MAX_W-w)>>1 and y_off=(MAX_H-h)>>1 are latched at header accept and added to x and line respectively.
- Undefined: offsets are 0, and the image sits at top-left line 0 / column 0.

Test Plan:
- Valid 4x2 24bpp, height=+2, data_start=54 (row pad 0) -> 8 words; first word at addr 512 (line 1), last at addr 3; loaded=1 after the final ack; error=0.
- 3x2 24bpp, height=-2, pixel 0 bytes 0x10,0x20,0x30 -> mem_d=0x00302010 at addr 0; the 3 pad bytes per row are skipped; row 1 writes at 512..514.
- 2x1 32bpp, alpha=0xFF -> mem_d[31:24]=0, 2 words; the alpha byte does not shift pixel alignment.
- Header with bpp=16, or width=600 -> error=1 at byte 29, no mem_req toggle, loaded=0 at download end.
- Download of a 4x4 image ending after 10 pixels -> error=1, loaded=0. Mem_ack held off across 2 pixels -> overrun error=1.
- With BMP_CENTER_EN, a 4x2 top-down image -> first word at line 155, x 254: addr (155<<9)+254=79614. Reset asserted mid-pixels -> all outputs 0, rest of that download ignored.
